// File: rtl/soml_qostbc_encoder.sv
// SOML quasi-orthogonal (Jafarkhani) 4x4 space-time block encoder: one 4-symbol block in, four slot beats out.
// Optional build macro SOML_ENC_SCALE_EN: arithmetic right shift by 1 (floor) on every output component.
//
// state  | meaning
// IDLE   | no block held, in_ready=1, out_valid=0
// SEND   | block latched, presenting slot r_slot until out_ready handshakes it

module soml_qostbc_encoder #(
  parameter int N = 16,
  parameter int Q = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [4*N-1:0] sym_r,
  input  logic [4*N-1:0] sym_i,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*N-1:0] out_r,
  output logic [4*N-1:0] out_i,
  output logic [1:0]     out_slot,
  output logic           out_last,
  output logic           blk_done
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

`ifdef SOML_ENC_SCALE_EN
  localparam int SCALE_SH = 1;
`else
  localparam int SCALE_SH = 0;
`endif
  // Scaling never shifts away more than the fractional bits.
  localparam int SHIFT = (SCALE_SH < Q) ? SCALE_SH : Q;

  localparam logic [N-1:0] MIN_V = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] MAX_V = {1'b0, {(N-1){1'b1}}};

  function automatic logic [N-1:0] f_neg(input logic [N-1:0] x);
    if (x == MIN_V) return MAX_V;
    return ~x + 1'b1;
  endfunction

  function automatic logic [N-1:0] f_out(input logic [N-1:0] x);
    return $signed(x) >>> SHIFT;
  endfunction

  logic [0:0]     r_state;
  logic [4*N-1:0] r_sym_r;
  logic [4*N-1:0] r_sym_i;
  logic [1:0]     r_slot;
  logic           r_out_valid;
  logic [4*N-1:0] r_out_r;
  logic [4*N-1:0] r_out_i;

  logic           w_in_ready;
  logic           w_accept;
  logic           w_hs;
  logic           w_last_hs;
  logic [1:0]     w_nslot;
  logic [4*N-1:0] w_src_r;
  logic [4*N-1:0] w_src_i;
  logic [4*N-1:0] w_cw_r;
  logic [4*N-1:0] w_cw_i;
  logic [N-1:0]   w_sr [4];
  logic [N-1:0]   w_si [4];
  logic [N-1:0]   w_nr [4];
  logic [N-1:0]   w_ni [4];
  logic [N-1:0]   w_raw_r [4];
  logic [N-1:0]   w_raw_i [4];

  assign w_in_ready = (r_state == S_IDLE) ||
                      ((r_state == S_SEND) && (r_slot == 2'd3) && out_ready);
  assign w_accept   = in_valid && w_in_ready;
  assign w_hs       = r_out_valid && out_ready;
  assign w_last_hs  = w_hs && (r_slot == 2'd3);

  // The next beat comes from the incoming block on acceptance, else from the latched block.
  assign w_nslot = w_accept ? 2'd0 : (r_slot + 2'd1);
  assign w_src_r = w_accept ? sym_r : r_sym_r;
  assign w_src_i = w_accept ? sym_i : r_sym_i;

  for (genvar k = 0; k < 4; k++) begin : g_unpack
    assign w_sr[k] = w_src_r[N*k +: N];
    assign w_si[k] = w_src_i[N*k +: N];
    assign w_nr[k] = f_neg(w_sr[k]);
    assign w_ni[k] = f_neg(w_si[k]);
  end

  // Symbol index 0 is s1. conj flips imag sign, so -conj(x) = (-xr, xi).
  always_comb begin
    for (int a = 0; a < 4; a++) begin
      w_raw_r[a] = '0;
      w_raw_i[a] = '0;
    end
    case (w_nslot)
      2'd0: begin
        w_raw_r[0] = w_sr[0]; w_raw_i[0] = w_si[0];
        w_raw_r[1] = w_sr[1]; w_raw_i[1] = w_si[1];
        w_raw_r[2] = w_sr[2]; w_raw_i[2] = w_si[2];
        w_raw_r[3] = w_sr[3]; w_raw_i[3] = w_si[3];
      end
      2'd1: begin
        w_raw_r[0] = w_nr[1]; w_raw_i[0] = w_si[1];
        w_raw_r[1] = w_sr[0]; w_raw_i[1] = w_ni[0];
        w_raw_r[2] = w_nr[3]; w_raw_i[2] = w_si[3];
        w_raw_r[3] = w_sr[2]; w_raw_i[3] = w_ni[2];
      end
      2'd2: begin
        w_raw_r[0] = w_nr[2]; w_raw_i[0] = w_si[2];
        w_raw_r[1] = w_nr[3]; w_raw_i[1] = w_si[3];
        w_raw_r[2] = w_sr[0]; w_raw_i[2] = w_ni[0];
        w_raw_r[3] = w_sr[1]; w_raw_i[3] = w_ni[1];
      end
      default: begin
        w_raw_r[0] = w_sr[3]; w_raw_i[0] = w_si[3];
        w_raw_r[1] = w_nr[2]; w_raw_i[1] = w_ni[2];
        w_raw_r[2] = w_nr[1]; w_raw_i[2] = w_ni[1];
        w_raw_r[3] = w_sr[0]; w_raw_i[3] = w_si[0];
      end
    endcase
    w_cw_r = '0;
    w_cw_i = '0;
    for (int a = 0; a < 4; a++) begin
      w_cw_r[N*a +: N] = f_out(w_raw_r[a]);
      w_cw_i[N*a +: N] = f_out(w_raw_i[a]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sym_r     <= '0;
      r_sym_i     <= '0;
      r_slot      <= 2'd0;
      r_out_valid <= 1'b0;
      r_out_r     <= '0;
      r_out_i     <= '0;
    end else if (w_accept) begin
      r_state     <= S_SEND;
      r_sym_r     <= sym_r;
      r_sym_i     <= sym_i;
      r_slot      <= 2'd0;
      r_out_valid <= 1'b1;
      r_out_r     <= w_cw_r;
      r_out_i     <= w_cw_i;
    end else if (w_last_hs) begin
      r_state     <= S_IDLE;
      r_slot      <= 2'd0;
      r_out_valid <= 1'b0;
      r_out_r     <= '0;
      r_out_i     <= '0;
    end else if (w_hs) begin
      r_slot      <= w_nslot;
      r_out_r     <= w_cw_r;
      r_out_i     <= w_cw_i;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_r     = r_out_r;
  assign out_i     = r_out_i;
  assign out_slot  = r_slot;
  assign out_last  = r_out_valid && (r_slot == 2'd3);
  assign blk_done  = w_last_hs;

endmodule

// File: tb/tb_soml_qostbc_encoder.sv
// Scoreboard bench for soml_qostbc_encoder; expected slot beats are queued when a block is accepted.
// Build with SOML_ENC_SCALE_EN defined to check the scaled variant.

module tb_soml_qostbc_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] sym_r = '0;
  logic [63:0] sym_i = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_r;
  logic [63:0] out_i;
  logic [1:0]  out_slot;
  logic        out_last;
  logic        blk_done;

  int checks = 0;
  int failures = 0;
  bit rand_en = 1'b0;

  typedef struct packed {
    logic [1:0]  slot;
    logic [63:0] r;
    logic [63:0] i;
  } beat_t;
  beat_t sb[$];

  // Per (slot,ant): source symbol (2 bits each), negate flag, conjugate flag; index slot*4+ant.
  localparam logic [31:0] SRC_T  = 32'h1B4E_B1E4;
  localparam logic [15:0] NEG_T  = 16'h6350;
  localparam logic [15:0] CONJ_T = 16'h0FF0;

  soml_qostbc_encoder #(.N(16), .Q(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sym_r(sym_r), .sym_i(sym_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_i(out_i),
    .out_slot(out_slot), .out_last(out_last), .blk_done(blk_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] tb_neg(input logic [15:0] x);
    if (x == 16'h8000) return 16'h7FFF;
    return 16'h0000 - x;
  endfunction

  function automatic logic [15:0] tb_scale(input logic [15:0] x);
`ifdef SOML_ENC_SCALE_EN
    return {x[15], x[15:1]};
`else
    return x;
`endif
  endfunction

  function automatic void tb_cw(input logic [63:0] sr, input logic [63:0] si, input int slot,
                                output logic [63:0] er, output logic [63:0] ei);
    int k, idx;
    logic n, c;
    logic [15:0] xr, xi;
    er = '0;
    ei = '0;
    for (int a = 0; a < 4; a++) begin
      idx = slot * 4 + a;
      k   = int'(SRC_T[2*idx +: 2]);
      n   = NEG_T[idx];
      c   = CONJ_T[idx];
      xr  = sr[16*k +: 16];
      xi  = si[16*k +: 16];
      er[16*a +: 16] = tb_scale(n ? tb_neg(xr) : xr);
      ei[16*a +: 16] = tb_scale((n ^ c) ? tb_neg(xi) : xi);
    end
  endfunction

  // Entered and left at posedge+1; acceptance is observed at the negedge in between.
  task automatic drive_block(input logic [63:0] sr, input logic [63:0] si, output int waits);
    logic [63:0] er, ei;
    bit done = 1'b0;
    waits = 0;
    sym_r = sr;
    sym_i = si;
    in_valid = 1'b1;
    while (!done && waits < 50) begin
      @(negedge clk);
      if (in_ready) begin
        for (int s = 0; s < 4; s++) begin
          tb_cw(sr, si, s, er, ei);
          sb.push_back('{slot: 2'(s), r: er, i: ei});
        end
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL accept_timeout got=in_ready_low exp=accept");
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL drain got=%0d_pending exp=0", sb.size());
    end
  endtask

  always @(posedge clk) begin
    if (rand_en) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    beat_t b;
    if (out_valid && out_ready && rst_n) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat got=slot%0d exp=none", out_slot);
      end else begin
        b = sb.pop_front();
        if (out_slot !== b.slot || out_r !== b.r || out_i !== b.i ||
            out_last !== (b.slot == 2'd3) || blk_done !== (b.slot == 2'd3)) begin
          failures++;
          $display("FAIL beat got=slot%0d r=%h i=%h last=%b done=%b exp=slot%0d r=%h i=%h",
                   out_slot, out_r, out_i, out_last, blk_done, b.slot, b.r, b.i);
        end
      end
    end else if (rst_n) begin
      checks++;
      if (blk_done !== 1'b0) begin
        failures++;
        $display("FAIL blk_done_idle got=%b exp=0", blk_done);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_r !== '0 || out_i !== '0 || out_slot !== 2'd0 ||
        out_last !== 1'b0 || blk_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got=v%b r=%h i=%h s=%0d l=%b d=%b exp=all_zero",
               out_valid, out_r, out_i, out_slot, out_last, blk_done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int w;
    drive_block({16'h0000, 16'hFF00, 16'h0200, 16'h0100},
                {16'h0100, 16'h0040, 16'h0000, 16'h0080}, w);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_slot !== 2'(k)) begin
        failures++;
        $display("FAIL basic_beat got=v%b slot%0d exp=v1 slot%0d", out_valid, out_slot, k);
      end
      if (k == 1) begin
        checks++;
        if (out_r[15:0] !== tb_scale(16'hFE00) || out_i[15:0] !== tb_scale(16'h0000) ||
            out_r[31:16] !== tb_scale(16'h0100) || out_i[31:16] !== tb_scale(16'hFF80)) begin
          failures++;
          $display("FAIL basic_slot1 got=%h/%h %h/%h exp=fe00/0000 0100/ff80 (scaled if enabled)",
                   out_r[15:0], out_i[15:0], out_r[31:16], out_i[31:16]);
        end
      end
      if (k == 3) begin
        checks++;
        if (out_r[31:16] !== tb_scale(16'h0100) || out_i[31:16] !== tb_scale(16'hFFC0) ||
            out_last !== 1'b1 || blk_done !== 1'b1) begin
          failures++;
          $display("FAIL basic_slot3 got=%h/%h last=%b done=%b exp=0100/ffc0 last=1 done=1",
                   out_r[31:16], out_i[31:16], out_last, blk_done);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_idle got=v%b rdy%b exp=v0 rdy1", out_valid, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int w;
    logic [63:0] sr, si, er, ei;
    sr = {16'h1234, 16'h8000, 16'h7FFF, 16'hABCD};
    si = {16'h0001, 16'hFFFF, 16'h8000, 16'h4321};
    drive_block(sr, si, w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tb_cw(sr, si, 2, er, ei);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_slot !== 2'd2 || out_r !== er || out_i !== ei ||
          in_ready !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold got=v%b slot%0d r=%h i=%h rdy%b exp=slot2 r=%h i=%h rdy0",
                 out_valid, out_slot, out_r, out_i, in_ready, er, ei);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain(20);
  endtask

  task automatic test_back_to_back();
    int w;
    logic [63:0] br, bi, er, ei;
    br = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    bi = {16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF};
    drive_block({16'h0400, 16'h0300, 16'h0200, 16'h0100},
                {16'h0040, 16'h0030, 16'h0020, 16'h0010}, w);
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (out_slot !== 2'd3 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_slot3_ready got=slot%0d rdy%b exp=slot3 rdy1", out_slot, in_ready);
    end
    drive_block(br, bi, w);
    checks++;
    if (w !== 0) begin
      failures++;
      $display("FAIL b2b_accept_wait got=%0d exp=0", w);
    end
    tb_cw(br, bi, 0, er, ei);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_slot !== 2'd0 || out_r !== er || out_i !== ei) begin
      failures++;
      $display("FAIL b2b_no_gap got=v%b slot%0d r=%h i=%h exp=v1 slot0 r=%h i=%h",
               out_valid, out_slot, out_r, out_i, er, ei);
    end
    @(posedge clk); #1;
    drain(20);
  endtask

  task automatic test_saturation();
    int w;
    drive_block({16'h0000, 16'h0000, 16'h0000, 16'h8000},
                {16'h0000, 16'h0000, 16'h0000, 16'h8000}, w);
    @(posedge clk); #1;
    checks++;
    if (out_slot !== 2'd1 || out_r[31:16] !== tb_scale(16'h8000) ||
        out_i[31:16] !== tb_scale(16'h7FFF)) begin
      failures++;
      $display("FAIL sat_slot1_ant1 got=slot%0d %h/%h exp=slot1 8000/7fff (scaled if enabled)",
               out_slot, out_r[31:16], out_i[31:16]);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (out_slot !== 2'd3 || out_r[63:48] !== tb_scale(16'h8000) ||
        out_i[63:48] !== tb_scale(16'h8000)) begin
      failures++;
      $display("FAIL sat_slot3_ant3 got=slot%0d %h/%h exp=slot3 8000/8000 (scaled if enabled)",
               out_slot, out_r[63:48], out_i[63:48]);
    end
    drain(20);
  endtask

  task automatic test_reset_mid();
    int w;
    drive_block({16'h0044, 16'h0033, 16'h0022, 16'h0011},
                {16'h0055, 16'h0066, 16'h0077, 16'h0088}, w);
    @(posedge clk); #1;
    rst_n = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_r !== '0 || out_i !== '0 || out_slot !== 2'd0 ||
        out_last !== 1'b0 || blk_done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs got=v%b r=%h i=%h s=%0d exp=all_zero",
               out_valid, out_r, out_i, out_slot);
    end
    sb.delete();
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_in_ready got=%b exp=1", in_ready);
    end
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset_stale got=v%b slot%0d exp=v0", out_valid, out_slot);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_scale();
    int w;
    drive_block({16'h0000, 16'h0000, 16'h0000, 16'h0101},
                {16'h0000, 16'h0000, 16'h0000, 16'hFFFF}, w);
    @(negedge clk);
    checks++;
    if (out_r[15:0] !== tb_scale(16'h0101) || out_i[15:0] !== tb_scale(16'hFFFF)) begin
      failures++;
      $display("FAIL scale_slot0_ant0 got=%h/%h exp=%h/%h",
               out_r[15:0], out_i[15:0], tb_scale(16'h0101), tb_scale(16'hFFFF));
    end
    @(posedge clk); #1;
    drain(20);
  endtask

  task automatic test_random();
    int w;
    logic [63:0] sr, si;
    rand_en = 1'b1;
    for (int b = 0; b < 10; b++) begin
      sr = {$urandom(), $urandom()};
      si = {$urandom(), $urandom()};
      if (b == 3) sr[15:0] = 16'h8000;
      drive_block(sr, si, w);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    rand_en = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain(100);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    test_scale();
    test_random();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
